// File: rtl/mirfak_defines.sv
// Shared definitions for the mirfak data-side Wishbone bridge: FSM encoding and timeout defaults.
package mirfak_defines;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StResp  = 2'd2,
    StDrain = 2'd3
  } dwb_state_e;

  localparam int unsigned DwbTimeoutDefault = 255;
  localparam int unsigned DwbCntW           = 16;

endpackage

// File: rtl/mirfak_dwb_timeout.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags expiry at Timeout.
module mirfak_dwb_timeout
  import mirfak_defines::*;
#(
  parameter int unsigned Timeout = DwbTimeoutDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [DwbCntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (32'(count_q) >= Timeout);

endmodule

// File: rtl/mirfak_dwb_bridge.sv
// Load/store unit to Wishbone master bridge, one outstanding access at a time.
// Optional bus watchdog enabled by defining MIRFAK_DWB_TIMEOUT_EN.
module mirfak_dwb_bridge
  import mirfak_defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DwbTimeoutDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_dat_i,
  input  logic [3:0]  s_sel_i,
  input  logic        s_we_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        s_err_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i
);

  dwb_state_e  state_q, state_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_dat_q, m_dat_d;
  logic [3:0]  m_sel_q, m_sel_d;
  logic        m_we_q, m_we_d;
  logic        m_cyc_q, m_cyc_d;
  logic        m_stb_q, m_stb_d;
  logic [31:0] s_dat_q, s_dat_d;
  logic        s_ack_q, s_ack_d;
  logic        s_err_q, s_err_d;
  logic        expired;
  logic        resp;

  assign resp = m_ack_i | m_err_i;

`ifdef MIRFAK_DWB_TIMEOUT_EN
  logic timer_clear, timer_enable;
  assign timer_clear  = (state_q == StIdle) && s_cyc_i && s_stb_i;
  assign timer_enable = (state_q == StBusy) || (state_q == StDrain);

  mirfak_dwb_timeout #(
    .Timeout (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (timer_clear),
    .enable_i  (timer_enable),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    m_addr_d = m_addr_q;
    m_dat_d  = m_dat_q;
    m_sel_d  = m_sel_q;
    m_we_d   = m_we_q;
    m_cyc_d  = m_cyc_q;
    m_stb_d  = m_stb_q;
    s_dat_d  = s_dat_q;
    s_ack_d  = 1'b0;
    s_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_cyc_i && s_stb_i) begin
          m_addr_d = s_addr_i;
          m_dat_d  = s_dat_i;
          m_sel_d  = s_sel_i;
          m_we_d   = s_we_i;
          m_cyc_d  = 1'b1;
          m_stb_d  = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // A slave response beats both the watchdog and a simultaneous flush.
        if (resp) begin
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          s_ack_d = ~m_err_i;
          s_err_d = m_err_i;
          if (!m_err_i && !m_we_q) begin
            s_dat_d = m_dat_i;
          end
          state_d = StResp;
        end else if (expired) begin
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          s_err_d = 1'b1;
          state_d = StResp;
        end else if (!s_cyc_i) begin
          state_d = StDrain;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      StDrain: begin
        if (resp || expired) begin
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      m_addr_q <= '0;
      m_dat_q  <= '0;
      m_sel_q  <= '0;
      m_we_q   <= 1'b0;
      m_cyc_q  <= 1'b0;
      m_stb_q  <= 1'b0;
      s_dat_q  <= '0;
      s_ack_q  <= 1'b0;
      s_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_addr_q <= m_addr_d;
      m_dat_q  <= m_dat_d;
      m_sel_q  <= m_sel_d;
      m_we_q   <= m_we_d;
      m_cyc_q  <= m_cyc_d;
      m_stb_q  <= m_stb_d;
      s_dat_q  <= s_dat_d;
      s_ack_q  <= s_ack_d;
      s_err_q  <= s_err_d;
    end
  end

  assign m_addr_o = m_addr_q;
  assign m_dat_o  = m_dat_q;
  assign m_sel_o  = m_sel_q;
  assign m_we_o   = m_we_q;
  assign m_cyc_o  = m_cyc_q;
  assign m_stb_o  = m_stb_q;
  assign s_dat_o  = s_dat_q;
  assign s_ack_o  = s_ack_q;
  assign s_err_o  = s_err_q;

endmodule

// File: doc/mirfak_dwb_bridge.md
MIRFAK_DWB_BRIDGE -- requirements
Module: mirfak_dwb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY-state cycles before forced error, range 1..65535.
REQ-002 clk_i  input  1  core clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assertion, active-low.
REQ-004 s_addr_i/s_dat_i  input  32/32  request address and write data from the load/store unit.
REQ-005 s_sel_i  input  4  byte lane selects; s_we_i  input  1  write enable.
REQ-006 s_cyc_i/s_stb_i  input  1/1  request valid; held by the load/store unit until s_ack_o or s_err_o.
REQ-007 s_dat_o  output  32  registered read data; s_ack_o/s_err_o  output  1/1  one-cycle completion strobes.
REQ-008 m_addr_o/m_dat_o/m_sel_o/m_we_o  output  32/32/4/1  registered Wishbone master request.
REQ-009 m_cyc_o/m_stb_o  output  1/1  registered Wishbone cycle/strobe.
REQ-010 m_dat_i/m_ack_i/m_err_i  input  32/1/1  Wishbone slave response.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY, RESP, DRAIN.
REQ-012 IDLE: s_cyc_i&&s_stb_i SHALL latch addr/dat/sel/we into m_* and enter BUSY with m_cyc_o=m_stb_o=1 next cycle.
REQ-013 m_addr_o/m_dat_o/m_sel_o/m_we_o SHALL stay constant throughout BUSY.
REQ-014 BUSY with m_ack_i or m_err_i SHALL clear m_cyc_o/m_stb_o, latch m_dat_i into s_dat_o (on ack, read only), enter RESP.
REQ-015 RESP SHALL assert exactly one of s_ack_o (ack) or s_err_o (err/timeout) for one cycle, then return to IDLE.
REQ-016 m_ack_i and m_err_i together SHALL be treated as error.
REQ-017 Latency: request sampled cycle 0 -> m_stb_o cycle 1; response at cycle k -> s_ack_o/s_err_o at cycle k+1; minimum 3 cycles request to completion.
REQ-018 IDLE SHALL not start a new request in the cycle RESP strobes; a request still held in the following IDLE cycle is a new request.
REQ-019 s_cyc_i dropping during BUSY (pipeline flush) SHALL move to DRAIN; bus cycle continues unchanged.
REQ-020 DRAIN SHALL wait for m_ack_i/m_err_i/timeout, clear m_cyc_o/m_stb_o, return to IDLE without s_ack_o/s_err_o.
REQ-021 s_dat_o SHALL hold its last value except on a BUSY read ack.
REQ-022 Outputs s_ack_o, s_err_o SHALL never be high outside RESP.

Reset
REQ-023 rst_ni low SHALL immediately force IDLE, m_cyc_o=m_stb_o=m_we_o=0, s_ack_o=s_err_o=0, m_addr_o=m_dat_o=s_dat_o=0, m_sel_o=0, timeout counter=0.
REQ-024 Reset mid-transaction SHALL abandon it with no completion strobe; release SHALL be synchronised to clk_i by the instantiating top.

Configuration
REQ-025 Macro MIRFAK_DWB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on BUSY entry, increment each BUSY/DRAIN cycle, and on reaching TIMEOUT_CYCLES without response terminate as error (RESP with s_err_o, or silent in DRAIN).
REQ-026 Response in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win over timeout.
REQ-027 Macro undefined: no counter SHALL be synthesised; BUSY/DRAIN wait indefinitely.

Structure
REQ-028 State encodings (2-bit IDLE/BUSY/RESP/DRAIN) and default TIMEOUT_CYCLES SHALL live in the shared mirfak_defines package.
REQ-029 The timeout counter SHALL be sub-module mirfak_dwb_timeout (inputs clear, enable; output expired), instantiated only under MIRFAK_DWB_TIMEOUT_EN.

Verification
REQ-030 Read: s_addr_i=0x100, stb held, slave acks 2 cycles after m_stb_o with 0xDEADBEEF -> s_ack_o one cycle, s_dat_o=0xDEADBEEF, m_cyc_o low after ack.
REQ-031 Write: s_we_i=1, s_sel_i=4'b0011, s_dat_i=0x12341234, slave stalls 5 cycles -> m_* stable all 5 cycles, single s_ack_o, s_dat_o unchanged.
REQ-032 Error: m_ack_i=m_err_i=1 same cycle -> s_err_o only, s_ack_o stays 0.
REQ-033 Flush: s_cyc_i dropped 1 cycle into BUSY, ack 3 cycles later -> DRAIN, no s_ack_o, m_cyc_o held until ack; next request accepted afterwards.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=4): no slave response -> m_cyc_o drops, s_err_o 5 cycles after m_stb_o rise; ack on cycle 4 -> s_ack_o instead.
REQ-035 Reset: rst_ni low during BUSY -> m_cyc_o/m_stb_o 0 same cycle, no strobe, IDLE after release.
